// File: rtl/alu_seq.sv
// alu_seq: registered PIC16C5x-style ALU, DATA_WIDTH-generic, with optional iterative W*f multiply (ALU_MUL_EN).
// Latency: 1 cycle for every function; MULWF is DATA_WIDTH cycles after accept (ALU_MUL_EN builds only).
// Backpressure: o_rdy drops for the whole multiply and any request seen meanwhile is dropped; otherwise always ready.

`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 5
`define ALU_IDLE  5'd0
`define ALU_ADDWF 5'd1
`define ALU_SUBWF 5'd2
`define ALU_ANDWF 5'd3
`define ALU_IORWF 5'd4
`define ALU_XORWF 5'd5
`define ALU_COMF  5'd6
`define ALU_INCF  5'd7
`define ALU_DECF  5'd8
`define ALU_MOVF  5'd9
`define ALU_SWAPF 5'd10
`define ALU_BCF   5'd11
`define ALU_BSF   5'd12
`define ALU_RLF   5'd13
`define ALU_RRF   5'd14
`define ALU_ANDLW 5'd15
`define ALU_IORLW 5'd16
`define ALU_XORLW 5'd17
`define ALU_MULWF 5'd18
`endif

module alu_seq #(
  // Operand width; must be at least 8 (nibble carry) and even (SWAPF halves).
  parameter int DATA_WIDTH   = 8,
  parameter int STATUS_WIDTH = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_vld,
  output logic                          o_rdy,
  input  logic [`ALU_FUNC_WIDTH-1:0]    i_func,
  input  logic [DATA_WIDTH-1:0]         i_w,
  input  logic [DATA_WIDTH-1:0]         i_f,
  input  logic [DATA_WIDTH-1:0]         i_l,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_bit_sel,
  input  logic                          i_c_flag,
  input  logic [STATUS_WIDTH-1:0]       i_status,
  output logic                          o_vld,
  output logic [DATA_WIDTH-1:0]         o_result,
  output logic [DATA_WIDTH-1:0]         o_result_hi,
  output logic [STATUS_WIDTH-1:0]       o_status
);

  localparam int W = DATA_WIDTH;
  localparam int H = DATA_WIDTH / 2;

  localparam logic [W-1:0] ONE_W    = 1;
  localparam logic [W:0]   ONE_WX   = 1;
  localparam logic [W-1:0] IDLE_RES = 8'hEF;

  // Status vector layout: {Z, DC, C}
  localparam int SZ  = 2;
  localparam int SDC = 1;
  localparam int SC  = 0;

  // Carry/borrow chains. Subtract is f + ~w + 1 so the carry out is NOT borrow.
  logic [W:0] w_add_full;
  logic [W:0] w_sub_full;
  logic [4:0] w_add_nib;
  logic [4:0] w_sub_nib;

  assign w_add_full = {1'b0, i_f} + {1'b0, i_w};
  assign w_sub_full = {1'b0, i_f} + {1'b0, ~i_w} + ONE_WX;
  assign w_add_nib  = {1'b0, i_f[3:0]} + {1'b0, i_w[3:0]};
  assign w_sub_nib  = {1'b0, i_f[3:0]} + {1'b0, ~i_w[3:0]} + 5'd1;

  logic [W-1:0] w_bit_mask;
  assign w_bit_mask = ONE_W << i_bit_sel;

  logic [W-1:0] w_res;
  logic         w_z;
  logic         w_dc;
  logic         w_c;

  // Single-cycle function decode: result plus next {Z, DC, C}
  always_comb begin
    w_res = IDLE_RES;
    w_dc  = i_status[SDC];
    w_c   = i_status[SC];
    case (i_func)
      `ALU_ADDWF: begin
        w_res = w_add_full[W-1:0];
        w_c   = w_add_full[W];
        w_dc  = w_add_nib[4];
      end
      `ALU_SUBWF: begin
        w_res = w_sub_full[W-1:0];
        w_c   = w_sub_full[W];
        w_dc  = w_sub_nib[4];
      end
      `ALU_ANDWF: w_res = i_w & i_f;
      `ALU_IORWF: w_res = i_w | i_f;
      `ALU_XORWF: w_res = i_w ^ i_f;
      `ALU_ANDLW: w_res = i_w & i_l;
      `ALU_IORLW: w_res = i_w | i_l;
      `ALU_XORLW: w_res = i_w ^ i_l;
      `ALU_COMF:  w_res = ~i_f;
      `ALU_INCF:  w_res = i_f + ONE_W;
      `ALU_DECF:  w_res = i_f - ONE_W;
      `ALU_MOVF:  w_res = i_f;
      `ALU_SWAPF: w_res = {i_f[H-1:0], i_f[W-1:H]};
      `ALU_BCF:   w_res = i_f & ~w_bit_mask;
      `ALU_BSF:   w_res = i_f | w_bit_mask;
      // Rotates through carry: the shifted-out bit is ORed into the incoming C.
      `ALU_RLF: begin
        w_res = {i_f[W-2:0], i_c_flag};
        w_c   = i_status[SC] | i_f[W-1];
      end
      `ALU_RRF: begin
        w_res = {i_c_flag, i_f[W-1:1]};
        w_c   = i_status[SC] | i_f[0];
      end
      default: w_res = IDLE_RES;
    endcase
    // Rotates leave Z alone; every other function recomputes it.
    if (i_func == `ALU_RLF || i_func == `ALU_RRF) begin
      w_z = i_status[SZ];
    end else begin
      w_z = (w_res == '0);
    end
  end

  logic                    r_vld;
  logic [W-1:0]            r_result;
  logic [W-1:0]            r_result_hi;
  logic [STATUS_WIDTH-1:0] r_status;

  assign o_vld       = r_vld;
  assign o_result    = r_result;
  assign o_status    = r_status;

`ifdef ALU_MUL_EN

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  // One bit wider than the product so the running sum can never wrap.
  logic [2*W:0]    r_acc;
  logic [2*W:0]    r_mcand;
  logic [W-1:0]    r_mplier;
  logic            r_mul_dc;
  logic [2*W:0]    w_acc_nxt;

  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_rdy       = (r_state == ST_IDLE);
  assign o_result_hi = r_result_hi;

  // Accept/write-back FSM; the multiply adds one shifted partial product per cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_vld       <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_status    <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_mul_dc    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_vld) begin
            if (i_func == `ALU_MULWF) begin
              r_state  <= ST_MUL;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= {{(W + 1){1'b0}}, i_w};
              r_mplier <= i_f;
              r_mul_dc <= i_status[SDC];
            end else begin
              r_vld       <= 1'b1;
              r_result    <= w_res;
              r_result_hi <= '0;
              r_status    <= {w_z, w_dc, w_c};
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_ONE;
          // Last partial product: publish straight from the adder output.
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_IDLE;
            r_vld       <= 1'b1;
            r_result    <= w_acc_nxt[W-1:0];
            r_result_hi <= w_acc_nxt[2*W-1:W];
            r_status    <= {(w_acc_nxt == '0), r_mul_dc, (w_acc_nxt[2*W:W] != '0)};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`else

  assign o_rdy       = 1'b1;
  assign o_result_hi = '0;
  assign r_result_hi = '0;

  // Every request (MULWF included, as an unknown code) completes in one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld    <= 1'b0;
      r_result <= '0;
      r_status <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_result <= w_res;
        r_status <= {w_z, w_dc, w_c};
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at DATA_WIDTH 8 and 16.
// Multiply scenarios follow the ALU_MUL_EN setting of the build.
// Expected values are hand-computed constants.
module tb_alu_seq;

  localparam logic [4:0] F_IDLE  = 5'd0,  F_ADDWF = 5'd1,  F_SUBWF = 5'd2,  F_ANDWF = 5'd3;
  localparam logic [4:0] F_IORWF = 5'd4,  F_XORWF = 5'd5,  F_COMF  = 5'd6,  F_INCF  = 5'd7;
  localparam logic [4:0] F_DECF  = 5'd8,  F_MOVF  = 5'd9,  F_SWAPF = 5'd10, F_BCF   = 5'd11;
  localparam logic [4:0] F_BSF   = 5'd12, F_RLF   = 5'd13, F_RRF   = 5'd14, F_ANDLW = 5'd15;
  localparam logic [4:0] F_IORLW = 5'd16, F_XORLW = 5'd17, F_MULWF = 5'd18, F_BAD   = 5'd31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [4:0] func = '0;
  logic [7:0] w = '0, f = '0, l = '0;
  logic [2:0] bsel = '0;
  logic       cfl = 1'b0;
  logic [2:0] st = '0;
  logic       rdy, ovld;
  logic [7:0] res, res_hi;
  logic [2:0] ost;

  logic        vld16 = 1'b0;
  logic [4:0]  func16 = '0;
  logic [15:0] w16 = '0, f16 = '0, l16 = '0;
  logic [3:0]  bsel16 = '0;
  logic        cfl16 = 1'b0;
  logic [2:0]  st16 = '0;
  logic        rdy16, ovld16;
  logic [15:0] res16, res_hi16;
  logic [2:0]  ost16;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(rdy), .i_func(func),
    .i_w(w), .i_f(f), .i_l(l), .i_bit_sel(bsel), .i_c_flag(cfl), .i_status(st),
    .o_vld(ovld), .o_result(res), .o_result_hi(res_hi), .o_status(ost)
  );

  alu_seq #(.DATA_WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_vld(vld16), .o_rdy(rdy16), .i_func(func16),
    .i_w(w16), .i_f(f16), .i_l(l16), .i_bit_sel(bsel16), .i_c_flag(cfl16), .i_status(st16),
    .o_vld(ovld16), .o_result(res16), .o_result_hi(res_hi16), .o_status(ost16)
  );

  // Present one request for one edge, then sample #1 after that edge.
  task automatic apply8(input logic [4:0] fn, input logic [7:0] fw, input logic [7:0] ff,
                        input logic [7:0] fl, input logic [2:0] bs, input logic cf, input logic [2:0] s);
    func = fn; w = fw; f = ff; l = fl; bsel = bs; cfl = cf; st = s; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic apply16(input logic [4:0] fn, input logic [15:0] fw, input logic [15:0] ff,
                         input logic [2:0] s);
    func16 = fn; w16 = fw; f16 = ff; l16 = '0; bsel16 = '0; cfl16 = 1'b0; st16 = s; vld16 = 1'b1;
    @(posedge clk); #1;
    vld16 = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got, exp;
    logic [36:0] got16, exp16;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {rdy, ovld, res_hi, res, ost};
    exp = {1'b1, 1'b0, 8'h00, 8'h00, 3'b000};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset8 got=%h exp=%h", got, exp); end
    got16 = {rdy16, ovld16, res_hi16, res16, ost16};
    exp16 = {1'b1, 1'b0, 16'h0000, 16'h0000, 3'b000};
    n_vec++;
    if (got16 !== exp16) begin n_err++; $display("FAIL reset16 got=%h exp=%h", got16, exp16); end
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [4:0] fn;
    logic [7:0] w;
    logic [7:0] f;
    logic [7:0] l;
    logic [2:0] bs;
    logic       cf;
    logic [2:0] st;
    logic [7:0] res;
    logic [2:0] ost;
  } vec_t;

  task automatic test_single_cycle();
    vec_t v[21];
    logic [20:0] got, exp;
    //            fn       w      f      l      bs    cf    st      res    {Z,DC,C}
    v[0]  = '{F_ADDWF, 8'h01, 8'h0F, 8'h00, 3'd0, 1'b0, 3'b000, 8'h10, 3'b010};
    v[1]  = '{F_ADDWF, 8'h80, 8'h80, 8'h00, 3'd0, 1'b0, 3'b000, 8'h00, 3'b101};
    v[2]  = '{F_SUBWF, 8'h05, 8'h05, 8'h00, 3'd0, 1'b0, 3'b000, 8'h00, 3'b111};
    v[3]  = '{F_SUBWF, 8'h06, 8'h05, 8'h00, 3'd0, 1'b0, 3'b111, 8'hFF, 3'b000};
    v[4]  = '{F_RRF,   8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 3'b000, 8'h80, 3'b001};
    v[5]  = '{F_RLF,   8'h00, 8'h80, 8'h00, 3'd0, 1'b0, 3'b010, 8'h00, 3'b011};
    v[6]  = '{F_BSF,   8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 3'b000, 8'h80, 3'b000};
    v[7]  = '{F_BCF,   8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 3'b011, 8'hFE, 3'b011};
    v[8]  = '{F_SWAPF, 8'h00, 8'hA5, 8'h00, 3'd0, 1'b0, 3'b000, 8'h5A, 3'b000};
    v[9]  = '{F_ANDWF, 8'h0F, 8'hF0, 8'h00, 3'd0, 1'b0, 3'b011, 8'h00, 3'b111};
    v[10] = '{F_IORWF, 8'h0F, 8'hF0, 8'h00, 3'd0, 1'b0, 3'b000, 8'hFF, 3'b000};
    v[11] = '{F_XORWF, 8'hFF, 8'h0F, 8'h00, 3'd0, 1'b0, 3'b000, 8'hF0, 3'b000};
    v[12] = '{F_XORLW, 8'h3C, 8'h00, 8'h3C, 3'd0, 1'b0, 3'b000, 8'h00, 3'b100};
    v[13] = '{F_ANDLW, 8'hAA, 8'hFF, 8'h0F, 3'd0, 1'b0, 3'b000, 8'h0A, 3'b000};
    v[14] = '{F_IORLW, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 3'b000, 8'h00, 3'b100};
    v[15] = '{F_COMF,  8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 3'b010, 8'h00, 3'b110};
    v[16] = '{F_INCF,  8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 3'b001, 8'h00, 3'b101};
    v[17] = '{F_DECF,  8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 3'b000, 8'h00, 3'b100};
    v[18] = '{F_MOVF,  8'h00, 8'h7E, 8'h00, 3'd0, 1'b0, 3'b011, 8'h7E, 3'b011};
    v[19] = '{F_BAD,   8'h12, 8'h34, 8'h56, 3'd0, 1'b0, 3'b011, 8'hEF, 3'b011};
    v[20] = '{F_IDLE,  8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'b000, 8'hEF, 3'b000};
    for (int i = 0; i < 21; i++) begin
      apply8(v[i].fn, v[i].w, v[i].f, v[i].l, v[i].bs, v[i].cf, v[i].st);
      got = {rdy, ovld, res_hi, res, ost};
      exp = {1'b1, 1'b1, 8'h00, v[i].res, v[i].ost};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL vec%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    func = F_ADDWF; w = 8'h01; f = 8'h0F; st = 3'b000; vld = 1'b1;
    @(posedge clk); #1;
    func = F_SUBWF; w = 8'h05; f = 8'h05;
    got = {ovld, res, ost}; exp = {1'b1, 8'h10, 3'b010};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    vld = 1'b0; func = F_ADDWF; w = 8'hFF; f = 8'hFF;
    got = {ovld, res, ost}; exp = {1'b1, 8'h00, 3'b111};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    got = {ovld, res, ost}; exp = {1'b0, 8'h00, 3'b111};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL b2b_hold got=%h exp=%h", got, exp); end
  endtask

  task automatic test_rst_priority();
    logic [20:0] got, exp;
    apply8(F_ADDWF, 8'h01, 8'h02, 8'h00, 3'd0, 1'b0, 3'b000);
    func = F_ADDWF; w = 8'h10; f = 8'h20; vld = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; rst = 1'b0;
    got = {rdy, ovld, res_hi, res, ost}; exp = {1'b1, 1'b0, 8'h00, 8'h00, 3'b000};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL rst_priority got=%h exp=%h", got, exp); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [20:0] got, exp;
    int cyc;
    int rdy_early;
    int seen;
    // 0x0F * 0x11 with an ADDWF pulse injected mid-multiply
    apply8(F_MULWF, 8'h0F, 8'h11, 8'h00, 3'd0, 1'b0, 3'b010);
    n_vec++;
    if ({rdy, ovld} !== 2'b00) begin n_err++; $display("FAIL mul_busy got=%b exp=00", {rdy, ovld}); end
    cyc = 0; rdy_early = 0;
    while (cyc < 40) begin
      if (cyc == 2) begin func = F_ADDWF; w = 8'h01; f = 8'h01; vld = 1'b1; end
      else vld = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (ovld) break;
      if (rdy) rdy_early++;
    end
    vld = 1'b0;
    n_vec++;
    if (cyc != 8 || rdy_early != 0) begin
      n_err++; $display("FAIL mul_latency got=%0d early_rdy=%0d exp=8", cyc, rdy_early);
    end
    got = {rdy, ovld, res_hi, res, ost}; exp = {1'b1, 1'b1, 8'h00, 8'hFF, 3'b010};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mul_0f_11 got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    got = {rdy, ovld, res_hi, res, ost}; exp = {1'b1, 1'b0, 8'h00, 8'hFF, 3'b010};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mul_hold got=%h exp=%h", got, exp); end
    // 0xFF * 0xFF
    apply8(F_MULWF, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 3'b000);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ovld) break;
    end
    got = {rdy, ovld, res_hi, res, ost}; exp = {1'b1, 1'b1, 8'hFE, 8'h01, 3'b001};
    n_vec++;
    if (cyc != 8 || got !== exp) begin n_err++; $display("FAIL mul_ff_ff cyc=%0d got=%h exp=%h", cyc, got, exp); end
    // Abort with reset at step 3
    apply8(F_MULWF, 8'h0F, 8'h11, 8'h00, 3'd0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got = {rdy, ovld, res_hi, res, ost}; exp = {1'b1, 1'b0, 8'h00, 8'h00, 3'b000};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mul_abort got=%h exp=%h", got, exp); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ovld) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL mul_abort_quiet got=%0d pulses exp=0", seen); end
  endtask
`else
  task automatic test_mul();
    logic [20:0] got, exp;
    apply8(F_MULWF, 8'h0F, 8'h11, 8'h00, 3'd0, 1'b0, 3'b011);
    got = {rdy, ovld, res_hi, res, ost}; exp = {1'b1, 1'b1, 8'h00, 8'hEF, 3'b011};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mul_disabled got=%h exp=%h", got, exp); end
  endtask
`endif

  task automatic test_width16();
    logic [36:0] got, exp;
    int cyc;
    apply16(F_ADDWF, 16'h0F01, 16'h00FF, 3'b000);
    got = {rdy16, ovld16, res_hi16, res16, ost16}; exp = {1'b1, 1'b1, 16'h0000, 16'h1000, 3'b010};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL w16_add got=%h exp=%h", got, exp); end
    apply16(F_SUBWF, 16'h1234, 16'h1234, 3'b000);
    got = {rdy16, ovld16, res_hi16, res16, ost16}; exp = {1'b1, 1'b1, 16'h0000, 16'h0000, 3'b111};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL w16_sub_eq got=%h exp=%h", got, exp); end
    apply16(F_SUBWF, 16'h0001, 16'h0000, 3'b111);
    got = {rdy16, ovld16, res_hi16, res16, ost16}; exp = {1'b1, 1'b1, 16'h0000, 16'hFFFF, 3'b000};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL w16_sub_borrow got=%h exp=%h", got, exp); end
    apply16(F_SWAPF, 16'h0000, 16'hA5C3, 3'b000);
    got = {rdy16, ovld16, res_hi16, res16, ost16}; exp = {1'b1, 1'b1, 16'h0000, 16'hC3A5, 3'b000};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL w16_swap got=%h exp=%h", got, exp); end
`ifdef ALU_MUL_EN
    apply16(F_MULWF, 16'hFFFF, 16'hFFFF, 3'b010);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (ovld16) break;
    end
    got = {rdy16, ovld16, res_hi16, res16, ost16}; exp = {1'b1, 1'b1, 16'hFFFE, 16'h0001, 3'b011};
    n_vec++;
    if (cyc != 16 || got !== exp) begin n_err++; $display("FAIL w16_mul cyc=%0d got=%h exp=%h", cyc, got, exp); end
`else
    cyc = 0;
    apply16(F_MULWF, 16'hFFFF, 16'hFFFF, 3'b010);
    got = {rdy16, ovld16, res_hi16, res16, ost16}; exp = {1'b1, 1'b1, 16'h0000, 16'h00EF, 3'b010};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL w16_mul_disabled cyc=%0d got=%h exp=%h", cyc, got, exp); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_back_to_back();
    test_rst_priority();
    test_mul();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle PIC16C5x ALU. It keeps the full byte-oriented, bit-oriented and literal function set and the {Z, DC, C} status semantics, generalised to DATA_WIDTH. It adds a valid/ready handshake and an optional iterative W×f multiply. It sits between the decode/operand-fetch stage and write-back, so the core can stall on multi-cycle operations.

## Interface
- DATA_WIDTH, 8: operand/result width. Must be ≥ 8 and even.
- STATUS_WIDTH, 3: status vector {Z, DC, C}. Fixed at 3.
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- validIn  input  1  operation request
- readyOut  output  1  block can accept a request this cycle
- funcIn  input  `ALU_FUNC_WIDTH  function code (define.v encodings, plus `ALU_MULWF)
- wIn, fIn, lIn  input  DATA_WIDTH  W register, file register, literal
- bitSel  input  $clog2(DATA_WIDTH)  bit index for BCF/BSF
- cFlag  input  1  carry in for RLF/RRF
- statusIn  input  3  current status
- validOut  output  1  one-cycle pulse: result/status valid
- aluResultOut  output  DATA_WIDTH  result (low half of product for MULWF)
- aluResultHiOut  output  DATA_WIDTH  high half of product; 0 for all other ops
- aluStatusOut  output  3  {Z, DC, C}

## Operation
- Accept occurs on a rising edge where validIn && readyOut. All inputs are captured at accept; later input changes have no effect.
- States: IDLE, MUL. readyOut = (state == IDLE). validIn in MUL is ignored, not queued.
- Single-cycle ops (every function except MULWF) stay in IDLE and give throughput 1/cycle.
- ADDWF: result = f + w. C = carry out of MSB. DC = carry out of bit 3.
- SUBWF: result = f − w. C = NOT borrow out of MSB. DC = NOT borrow out of bit 3.
- Logic ops (AND/IOR/XOR with W or literal), COMF, INCF, DECF, MOVF: as named, modulo 2^DATA_WIDTH.
- SWAPF: exchanges the upper and lower DATA_WIDTH/2 halves.
- BCF/BSF: clear/set bit bitSel of f.
- RLF: {C, result} = {f, cFlag}. RRF: {C, result} = {f[0], cFlag, f[MSB:1]}. Z and DC come from statusIn; the C bit is ORed with the new carry.
- Z = (result == 0) for every op except RLF/RRF. DC and C pass through from statusIn where the op does not define them.
- IDLE or undefined funcIn: result = 8'hEF zero-extended to DATA_WIDTH; DC and C pass through. validOut still pulses.
- MULWF: unsigned radix-2 shift-add, one partial product per cycle, with a DATA_WIDTH-step counter.
  - Product P is 2·DATA_WIDTH bits: aluResultHiOut = P[2W−1:W], aluResultOut = P[W−1:0].
  - Z = (P == 0). C = (P[2W−1:W] != 0). DC unchanged.
  - No internal overflow: the accumulator is 2W+1 bits wide.

## Timing
- Reset: state = IDLE, readyOut = 1, validOut = 0, aluResultOut = 0, aluResultHiOut = 0, aluStatusOut = 0. The counter is cleared.
- Outputs are registered and hold their last value between validOut pulses.
- Single-cycle op accepted at edge k: outputs update and validOut = 1 after edge k, for exactly one cycle unless another op is accepted at edge k+1.
- MULWF accepted at edge k:
  - readyOut = 0 after edge k.
  - Iteration steps run on edges k+1 … k+DATA_WIDTH.
  - After edge k+DATA_WIDTH: outputs update, validOut = 1, readyOut = 1.
  - A new op may be accepted at edge k+DATA_WIDTH+1.
- rst asserted mid-MULWF: the op is aborted, no validOut is produced, and all reset values apply after that edge.
- rst has priority over an accept on the same edge.

## Configuration
- ALU_MUL_EN defined: MULWF, the MUL state, the counter and the accumulator are built.
- ALU_MUL_EN undefined: no MUL state. `ALU_MULWF is treated as an undefined code (single-cycle, result 8'hEF extended). readyOut is tied to 1 and aluResultHiOut is tied to 0.

## Test plan
- ADDWF w=0x01 f=0x0F (W=8) → validOut next cycle, result 0x10, status {0,1,0}. ADDWF w=0x80 f=0x80 → 0x00, {1,0,1}.
- SUBWF w=0x05 f=0x05 → 0x00, {1,1,1}. SUBWF w=0x06 f=0x05 → 0xFF, {0,0,0}.
- RRF f=0x01 cFlag=1 statusIn=0 → 0x80, C=1. BSF f=0x00 bitSel=7 → 0x80. SWAPF 0xA5 → 0x5A. Back-to-back accepts on consecutive cycles → validOut high on each following cycle.
- MULWF w=0x0F f=0x11 → readyOut low for 8 cycles, then hi=0x00 lo=0xFF, C=0, Z=0. MULWF 0xFF×0xFF → hi=0xFE lo=0x01, C=1.
- During MULWF, pulse validIn with ADDWF → ignored; only the MUL result appears. rst at step 3 → next cycle readyOut=1, validOut=0, outputs 0.
- Repeat ADDWF/SUBWF/MULWF with DATA_WIDTH=16 (0xFFFF×0xFFFF → hi 0xFFFE lo 0x0001). Build without ALU_MUL_EN → MULWF returns 0x00EF after 1 cycle.
